kpn_queue_write_arbiter: RTL

//  Round-robin write arbiter for a KPN channel queue: lets NUM_REQ producer processes share one FIFO write port.

---
 rtl/kpn_pkg.sv | 23 ++
 rtl/kpn_queue_write_arbiter_if.sv | 37 +++
 rtl/kpn_rr_picker.sv | 40 ++++
 rtl/kpn_queue_write_arbiter.sv | 112 +++++++++++
 4 files changed

// File: rtl/kpn_pkg.sv
// ============================================================================
// kpn_pkg : shared types and helpers for the KPN queue write arbiter
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package kpn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        STALL = 2'd2
    } arb_state_t;

    localparam int KPN_WORD_BITS = 16;

    function automatic logic [7:0] rr_onehot(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/kpn_queue_write_arbiter_if.sv
// ============================================================================
// kpn_queue_write_arbiter_if : producer/queue side bus of the write arbiter
// Optional statistics signals exist only with KPN_ARB_STATS_EN defined.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface kpn_queue_write_arbiter_if #(
    parameter int NUM_REQ     = 4,
    parameter int BITS_NUMBER = 16,
    parameter int CNT_BITS    = 16
);
    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ*BITS_NUMBER-1:0] data_in;
    logic                           fifo_full;
    logic                           fifo_afull;
    logic                           fifo_wr;
    logic [BITS_NUMBER-1:0]         fifo_data;
    logic [NUM_REQ-1:0]             ack;
    logic                           busy;
`ifdef KPN_ARB_STATS_EN
    logic [CNT_BITS-1:0]            stall_cnt;
    logic [NUM_REQ*CNT_BITS-1:0]    grant_cnt;

    modport master (output req, data_in, fifo_full, fifo_afull,
                    input  fifo_wr, fifo_data, ack, busy, stall_cnt, grant_cnt);
    modport slave  (input  req, data_in, fifo_full, fifo_afull,
                    output fifo_wr, fifo_data, ack, busy, stall_cnt, grant_cnt);
`else
    modport master (output req, data_in, fifo_full, fifo_afull,
                    input  fifo_wr, fifo_data, ack, busy);
    modport slave  (input  req, data_in, fifo_full, fifo_afull,
                    output fifo_wr, fifo_data, ack, busy);
`endif
endinterface

`default_nettype wire

// File: rtl/kpn_rr_picker.sv
// ============================================================================
// kpn_rr_picker : combinational round-robin search, first eligible at/above ptr
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module kpn_rr_picker
    import kpn_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PW      = 2
) (
    input  wire logic [NUM_REQ-1:0] i_elig,
    input  wire logic [PW-1:0]      i_ptr,
    output logic                    o_valid,
    output logic [PW-1:0]           o_idx,
    output logic [NUM_REQ-1:0]      o_onehot
);
    logic [NUM_REQ-1:0] w_rot;
    logic [PW:0]        w_off;
    logic [PW:0]        w_sum;

    // Rotate so bit 0 is the pointer position; the lowest set bit is the winner.
    assign w_rot = NUM_REQ'({i_elig, i_elig} >> i_ptr);

    always_comb begin
        w_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) w_off = (PW+1)'(k);
        end
    end

    assign o_valid  = |i_elig;
    assign w_sum    = {1'b0, i_ptr} + w_off;
    assign o_idx    = (w_sum >= (PW+1)'(NUM_REQ)) ? PW'(w_sum - (PW+1)'(NUM_REQ)) : PW'(w_sum);
    assign o_onehot = o_valid ? NUM_REQ'(rr_onehot(3'(o_idx))) : '0;

endmodule

`default_nettype wire

// File: rtl/kpn_queue_write_arbiter.sv
// ============================================================================
// kpn_queue_write_arbiter : round-robin N:1 write arbiter for a KPN channel queue
// Optional macro KPN_ARB_STATS_EN adds stall/grant saturating counters.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module kpn_queue_write_arbiter
    import kpn_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int BITS_NUMBER = KPN_WORD_BITS,
    parameter int CNT_BITS    = 16
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    kpn_queue_write_arbiter_if.slave   bus
);
    localparam int PW = $clog2(NUM_REQ);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_GRANT = GRANT;
    localparam logic [1:0] ST_STALL = STALL;

    logic [1:0]             r_state;
    logic [PW-1:0]          r_ptr;
    logic                   r_wr;
    logic [BITS_NUMBER-1:0] r_data;
    logic [NUM_REQ-1:0]     r_ack;

    logic [NUM_REQ-1:0]     w_elig;
    logic                   w_space;
    logic                   w_valid;
    logic [PW-1:0]          w_idx;
    logic [NUM_REQ-1:0]     w_onehot;
    logic [BITS_NUMBER-1:0] w_word;
    logic [PW-1:0]          w_ptr_nxt;

    // Masking with the current ack stops a producer's stale word being taken twice.
    assign w_elig  = bus.req & ~r_ack;
    assign w_space = ~bus.fifo_full & ~(r_wr & bus.fifo_afull);

    kpn_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_picker (
        .i_elig   (w_elig),
        .i_ptr    (r_ptr),
        .o_valid  (w_valid),
        .o_idx    (w_idx),
        .o_onehot (w_onehot)
    );

    assign w_word    = bus.data_in[int'(w_idx)*BITS_NUMBER +: BITS_NUMBER];
    assign w_ptr_nxt = (w_idx == PW'(NUM_REQ - 1)) ? '0 : w_idx + PW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_wr    <= 1'b0;
            r_data  <= '0;
            r_ack   <= '0;
        end else if (w_valid && w_space) begin
            r_state <= ST_GRANT;
            r_ptr   <= w_ptr_nxt;
            r_wr    <= 1'b1;
            r_data  <= w_word;
            r_ack   <= w_onehot;
        end else begin
            r_state <= w_valid ? ST_STALL : ST_IDLE;
            r_wr    <= 1'b0;
            r_ack   <= '0;
        end
    end

    assign bus.fifo_wr   = r_wr;
    assign bus.fifo_data = r_data;
    assign bus.ack       = r_ack;
    assign bus.busy      = (r_state != ST_IDLE);

`ifdef KPN_ARB_STATS_EN
    logic [CNT_BITS-1:0] r_stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if ((r_state == ST_STALL) && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_BITS'(1);
        end
    end

    assign bus.stall_cnt = r_stall_cnt;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_grant_cnt
        logic [CNT_BITS-1:0] r_cnt;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_cnt <= '0;
            end else if (r_ack[g] && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_BITS'(1);
            end
        end

        assign bus.grant_cnt[g*CNT_BITS +: CNT_BITS] = r_cnt;
    end
`endif

endmodule

`default_nettype wire
